// File: rtl/systolic_result_drain_pkg.sv
// Shared definitions for the systolic array result path: lane width default,
// drain FSM states and the beat-count helper.
package systolic_pkg;

  localparam int BW_ACT_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/systolic_result_drain.sv
// Captures one full result set from the systolic array and streams it out as
// packed valid/ready beats, flagging captures that land while a drain is running.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int BN_NUM   = 10,
  parameter int BW_ACT   = BW_ACT_DEF,
  parameter int PACK_NUM = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cap_valid,
  input  logic signed [BW_ACT-1:0]   res_in [BN_NUM],
  output logic                       cap_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PACK_NUM*BW_ACT-1:0] out_data,
  output logic [PACK_NUM-1:0]        out_keep,
  output logic                       out_last,
  output logic                       busy,
  output logic                       overrun_err,
  input  logic                       err_clear
);

  localparam int NBEATS = ceil_div(BN_NUM, PACK_NUM);
  localparam int IDXW   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [IDXW-1:0] LAST_BEAT = IDXW'(NBEATS - 1);

  drain_state_e state, state_next;
  logic [IDXW-1:0] beat_idx, beat_next;
  logic load;
  logic signed [BW_ACT-1:0] buffer [BN_NUM];

  logic [NBEATS-1:0][PACK_NUM-1:0][BW_ACT-1:0] beat_data;
  logic [NBEATS-1:0][PACK_NUM-1:0]             beat_keep;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      beat_idx    <= '0;
      overrun_err <= 1'b0;
      for (int i = 0; i < BN_NUM; i++) buffer[i] <= '0;
    end else begin
      state    <= state_next;
      beat_idx <= beat_next;
      if (load)
        for (int i = 0; i < BN_NUM; i++) buffer[i] <= res_in[i];
      // A capture offered while draining is dropped; setting beats a same-cycle clear.
      if (state == DRAIN && cap_valid)
        overrun_err <= 1'b1;
      else if (err_clear)
        overrun_err <= 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    beat_next  = beat_idx;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (cap_valid) begin
          load       = 1'b1;
          beat_next  = '0;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (beat_idx == LAST_BEAT) state_next = IDLE;
          else                       beat_next  = beat_idx + IDXW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Lanes past the end of the set are padded with zero and masked off.
  for (genvar b = 0; b < NBEATS; b++) begin : g_beat
    for (genvar j = 0; j < PACK_NUM; j++) begin : g_lane
      if (b * PACK_NUM + j < BN_NUM) begin : g_live
        assign beat_data[b][j] = buffer[b * PACK_NUM + j];
        assign beat_keep[b][j] = 1'b1;
      end else begin : g_pad
        assign beat_data[b][j] = '0;
        assign beat_keep[b][j] = 1'b0;
      end
    end
  end

  always_comb begin
    out_data = '0;
    out_keep = '0;
    if (state == DRAIN) begin
      for (int b = 0; b < NBEATS; b++) begin
        if (beat_idx == IDXW'(b)) begin
          out_data = beat_data[b];
          out_keep = beat_keep[b];
        end
      end
    end
  end

  assign cap_ready = (state == IDLE);
  assign out_valid = (state == DRAIN);
  assign busy      = (state == DRAIN);
  assign out_last  = (state == DRAIN) && (beat_idx == LAST_BEAT);

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed self-checking bench for systolic_result_drain: main 10x4 instance plus
// single-beat (PACK_NUM=10) and single-lane (PACK_NUM=1) instances.
module tb_systolic_result_drain;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic signed [7:0] res_in [10];

  logic cap_valid = 1'b0, out_ready = 1'b0, err_clear = 1'b0;
  logic cap_ready, out_valid, out_last, busy, overrun_err;
  logic [31:0] out_data;
  logic [3:0]  out_keep;

  logic cv_w = 1'b0, rdy_w = 1'b0;
  logic cr_w, ov_w, last_w, busy_w, oerr_w;
  logic [79:0] data_w;
  logic [9:0]  keep_w;

  logic cv_n = 1'b0, rdy_n = 1'b0;
  logic cr_n, ov_n, last_n, busy_n, oerr_n;
  logic [7:0] data_n;
  logic [0:0] keep_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  systolic_result_drain #(.BN_NUM(10), .BW_ACT(8), .PACK_NUM(4)) dut (
    .clk(clk), .reset_n(reset_n), .cap_valid(cap_valid), .res_in(res_in),
    .cap_ready(cap_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
    .busy(busy), .overrun_err(overrun_err), .err_clear(err_clear)
  );

  systolic_result_drain #(.BN_NUM(10), .BW_ACT(8), .PACK_NUM(10)) dut_wide (
    .clk(clk), .reset_n(reset_n), .cap_valid(cv_w), .res_in(res_in),
    .cap_ready(cr_w), .out_valid(ov_w), .out_ready(rdy_w),
    .out_data(data_w), .out_keep(keep_w), .out_last(last_w),
    .busy(busy_w), .overrun_err(oerr_w), .err_clear(1'b0)
  );

  systolic_result_drain #(.BN_NUM(10), .BW_ACT(8), .PACK_NUM(1)) dut_narrow (
    .clk(clk), .reset_n(reset_n), .cap_valid(cv_n), .res_in(res_in),
    .cap_ready(cr_n), .out_valid(ov_n), .out_ready(rdy_n),
    .out_data(data_n), .out_keep(keep_n), .out_last(last_n),
    .busy(busy_n), .overrun_err(oerr_n), .err_clear(1'b0)
  );

  localparam logic [31:0] BEAT_DATA [3] = '{32'h04030201, 32'h08070605, 32'h00000A09};
  localparam logic [3:0]  BEAT_KEEP [3] = '{4'b1111, 4'b1111, 4'b0011};

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadCount();
    for (int i = 0; i < 10; i++) res_in[i] = 8'(i + 1);
  endtask

  // One-cycle capture strobe on the main instance.
  task automatic applyStimulus();
    cap_valid = 1'b1;
    tick();
    cap_valid = 1'b0;
  endtask

  task automatic checkBeat(input string tag, input int k);
    checkOutput({tag, "_valid"}, 128'(out_valid), 128'(1));
    checkOutput({tag, "_data"},  128'(out_data),  128'(BEAT_DATA[k]));
    checkOutput({tag, "_keep"},  128'(out_keep),  128'(BEAT_KEEP[k]));
    checkOutput({tag, "_last"},  128'(out_last),  128'(k == 2));
  endtask

  initial begin
    logic bp_seq [6];
    int k;
    int hs;
    bp_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    loadCount();

    #12;
    checkOutput("rst_cap_ready", 128'(cap_ready), 128'(1));
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_busy",      128'(busy),      128'(0));
    checkOutput("rst_overrun",   128'(overrun_err), 128'(0));
    checkOutput("rst_data",      128'(out_data),  128'(0));
    reset_n = 1'b1;
    tick();

    // Basic drain, out_ready held high
    $display("[TB] basic drain");
    out_ready = 1'b1;
    applyStimulus();
    checkOutput("basic_cap_ready_busy", 128'(cap_ready), 128'(0));
    checkOutput("basic_busy", 128'(busy), 128'(1));
    for (int b = 0; b < 3; b++) begin
      checkBeat($sformatf("basic_b%0d", b), b);
      tick();
    end
    checkOutput("basic_cap_ready_done", 128'(cap_ready), 128'(1));
    checkOutput("basic_idle_valid", 128'(out_valid), 128'(0));

    // Back-pressure: beats must hold while stalled
    $display("[TB] back-pressure");
    out_ready = 1'b0;
    applyStimulus();
    k = 0;
    hs = 0;
    for (int i = 0; i < 6; i++) begin
      out_ready = bp_seq[i];
      if (k < 3) checkBeat($sformatf("bp_c%0d", i), k);
      tick();
      if (bp_seq[i]) begin
        k++;
        hs++;
      end
    end
    out_ready = 1'b0;
    checkOutput("bp_handshakes", 128'(hs), 128'(3));
    checkOutput("bp_cap_ready", 128'(cap_ready), 128'(1));

    // Signed pass-through
    $display("[TB] signed lanes");
    res_in[0] = -8'sd128;
    res_in[1] = 8'sd127;
    res_in[2] = -8'sd1;
    res_in[3] = 8'sd0;
    applyStimulus();
    checkOutput("signed_b0", 128'(out_data), 128'(32'h00FF7F80));
    out_ready = 1'b1;
    tick(); tick(); tick();
    out_ready = 1'b0;
    checkOutput("signed_idle", 128'(cap_ready), 128'(1));
    loadCount();

    // Overrun while stalled
    $display("[TB] overrun");
    applyStimulus();
    for (int i = 0; i < 10; i++) res_in[i] = 8'(8'h20 + i);
    cap_valid = 1'b1;
    tick();
    cap_valid = 1'b0;
    checkOutput("ovr_set", 128'(overrun_err), 128'(1));
    checkOutput("ovr_data_held", 128'(out_data), 128'(BEAT_DATA[0]));
    cap_valid = 1'b1;
    err_clear = 1'b1;
    tick();
    cap_valid = 1'b0;
    checkOutput("ovr_set_wins", 128'(overrun_err), 128'(1));
    tick();
    err_clear = 1'b0;
    checkOutput("ovr_cleared", 128'(overrun_err), 128'(0));
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      checkBeat($sformatf("ovr_b%0d", b), b);
      tick();
    end
    out_ready = 1'b0;
    loadCount();

    // Reset mid-drain
    $display("[TB] reset mid-drain");
    out_ready = 1'b1;
    applyStimulus();
    tick();
    checkBeat("rstmid_b1", 1);
    reset_n = 1'b0;
    #1;
    checkOutput("rstmid_valid", 128'(out_valid), 128'(0));
    checkOutput("rstmid_cap_ready", 128'(cap_ready), 128'(1));
    checkOutput("rstmid_data", 128'(out_data), 128'(0));
    checkOutput("rstmid_keep", 128'(out_keep), 128'(0));
    checkOutput("rstmid_last", 128'(out_last), 128'(0));
    checkOutput("rstmid_busy", 128'(busy), 128'(0));
    #3;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("rstmid_stray%0d", i), 128'(out_valid), 128'(0));
      checkOutput($sformatf("rstmid_ready%0d", i), 128'(cap_ready), 128'(1));
    end
    out_ready = 1'b0;

    // PACK_NUM == BN_NUM: one beat carrying everything
    $display("[TB] single-beat instance");
    rdy_w = 1'b1;
    cv_w = 1'b1;
    tick();
    cv_w = 1'b0;
    checkOutput("wide_valid", 128'(ov_w), 128'(1));
    checkOutput("wide_data", 128'(data_w), 128'(80'h0A090807060504030201));
    checkOutput("wide_keep", 128'(keep_w), 128'(10'h3FF));
    checkOutput("wide_last", 128'(last_w), 128'(1));
    tick();
    checkOutput("wide_done", 128'(cr_w), 128'(1));
    rdy_w = 1'b0;

    // PACK_NUM == 1: ten single-lane beats
    $display("[TB] single-lane instance");
    rdy_n = 1'b1;
    cv_n = 1'b1;
    tick();
    cv_n = 1'b0;
    for (int b = 0; b < 10; b++) begin
      checkOutput($sformatf("narrow_valid%0d", b), 128'(ov_n), 128'(1));
      checkOutput($sformatf("narrow_data%0d", b), 128'(data_n), 128'(b + 1));
      checkOutput($sformatf("narrow_keep%0d", b), 128'(keep_n), 128'(1));
      checkOutput($sformatf("narrow_last%0d", b), 128'(last_n), 128'(b == 9));
      tick();
    end
    checkOutput("narrow_done", 128'(cr_n), 128'(1));
    rdy_n = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
